// File: rtl/bp_be_pkg.sv
// Shared BE types and constants: processor config selector, issue-controller FSM states
// and the width of its event counters.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef enum logic [1:0] {
        e_run    = 2'd0,
        e_clr    = 2'd1,
        e_resync = 2'd2
    } bp_be_issue_ctrl_state_e;

    localparam int bp_be_issue_ctrl_stat_width_gp = 16;

    // Queue depth for each processor config.
    function automatic int bp_fe_queue_fifo_els(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 8;
            default:          return 8;
        endcase
    endfunction

endpackage

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter that stops at zero; set has priority over decrement.
module bsg_counter_set_down #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_r_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_r_o <= '0;
        else if (set_i)
            count_r_o <= val_i;
        else if (down_i && (count_r_o != '0))
            count_r_o <= count_r_o - width_p'(1);
    end

endmodule

// File: rtl/bp_be_issue_ctrl.sv
// BE issue-queue sequencing controller: yumi/deq/roll/clr generation, inflight tracking and
// post-redirect resync window. Define BP_BE_ISSUE_CTRL_STATS_EN to build roll/clr event counters.
module bp_be_issue_ctrl
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p     = e_bp_default_cfg,
    parameter int         resync_cycles_p = 2,
    localparam int        fe_queue_fifo_els_p = bp_fe_queue_fifo_els(bp_params_p),
    localparam int        cnt_width_lp        = $clog2(fe_queue_fifo_els_p + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      fe_queue_v_i,
    input  logic                                      dispatch_ready_i,
    input  logic                                      commit_v_i,
    input  logic                                      flush_v_i,
    input  logic                                      redirect_v_i,
    output logic                                      fe_queue_yumi_o,
    output logic                                      deq_v_o,
    output logic                                      roll_v_o,
    output logic                                      clr_v_o,
    output logic [cnt_width_lp-1:0]                   inflight_o,
    output logic                                      busy_o,
    output logic [bp_be_issue_ctrl_stat_width_gp-1:0] roll_cnt_o,
    output logic [bp_be_issue_ctrl_stat_width_gp-1:0] clr_cnt_o
);

    localparam int resync_width_lp = 4;

    bp_be_issue_ctrl_state_e state_r, state_n;
    logic [cnt_width_lp-1:0]    inflight_r, inflight_n;
    logic                       busy_r;
    logic [resync_width_lp-1:0] resync_cnt_r;
    logic                       resync_down;

    wire is_run    = (state_r == e_run);
    wire is_clr    = (state_r == e_clr);
    wire is_resync = (state_r == e_resync);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fe_queue_yumi_o = 1'b0;
        deq_v_o         = 1'b0;
        roll_v_o        = 1'b0;
        clr_v_o         = 1'b0;
        resync_down     = 1'b0;
        state_n         = state_r;
        if (!reset_i) begin
            fe_queue_yumi_o = fe_queue_v_i & dispatch_ready_i & is_run & ~flush_v_i & ~redirect_v_i;
            deq_v_o         = commit_v_i & (inflight_r != '0);
            roll_v_o        = flush_v_i;
            // A combined flush+redirect in e_run defers the clear by one cycle so it sees the rewound rptr.
            clr_v_o         = (is_run & redirect_v_i & ~flush_v_i) | is_clr | (is_resync & redirect_v_i);
            resync_down     = is_resync & ~redirect_v_i;
        end

        case (state_r)
            e_run: begin
                if (redirect_v_i && flush_v_i) state_n = e_clr;
                else if (redirect_v_i)         state_n = e_resync;
            end
            e_clr:    state_n = e_resync;
            e_resync: begin
                if (!redirect_v_i && (resync_cnt_r == '0)) state_n = e_run;
            end
            default:  state_n = e_run;
        endcase

        // Roll rewinds rptr to cptr+deq, so nothing issued survives it.
        inflight_n = roll_v_o ? '0
                   : inflight_r + cnt_width_lp'(fe_queue_yumi_o) - cnt_width_lp'(deq_v_o);
    end

    // Every clear (re)starts the resync window.
    bsg_counter_set_down #(
        .width_p (resync_width_lp)
    ) resync_counter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_i     (clr_v_o),
        .val_i     (resync_width_lp'(resync_cycles_p)),
        .down_i    (resync_down),
        .count_r_o (resync_cnt_r)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_run;
            inflight_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            inflight_r <= inflight_n;
            busy_r     <= (state_n != e_run);
        end
    end

    assign inflight_o = inflight_r;
    assign busy_o     = busy_r;

`ifdef BP_BE_ISSUE_CTRL_STATS_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            roll_cnt_o <= '0;
            clr_cnt_o  <= '0;
        end else begin
            if (roll_v_o && (roll_cnt_o != '1)) roll_cnt_o <= roll_cnt_o + 1'b1;
            if (clr_v_o && (clr_cnt_o != '1))   clr_cnt_o  <= clr_cnt_o + 1'b1;
        end
    end
`else
    assign roll_cnt_o = '0;
    assign clr_cnt_o  = '0;
`endif

`ifndef SYNTHESIS
    commit_without_inflight: assert property (@(posedge clk_i) disable iff (reset_i)
        !(commit_v_i && (inflight_r == '0)))
        else $error("commit with no inflight instruction");

    yumi_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(fe_queue_yumi_o && (inflight_r == cnt_width_lp'(fe_queue_fifo_els_p))))
        else $error("cannot occur given queue full logic");
`endif

endmodule

// File: tb/tb_bp_be_issue_ctrl.sv
// Directed-vector bench for bp_be_issue_ctrl (default config, resync_cycles_p=2).
module tb_bp_be_issue_ctrl;
    import bp_be_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fe_queue_v_i, dispatch_ready_i, commit_v_i, flush_v_i, redirect_v_i;
    logic        fe_queue_yumi_o, deq_v_o, roll_v_o, clr_v_o, busy_o;
    logic [3:0]  inflight_o;
    logic [15:0] roll_cnt_o, clr_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    bp_be_issue_ctrl dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .dispatch_ready_i (dispatch_ready_i),
        .commit_v_i       (commit_v_i),
        .flush_v_i        (flush_v_i),
        .redirect_v_i     (redirect_v_i),
        .fe_queue_yumi_o  (fe_queue_yumi_o),
        .deq_v_o          (deq_v_o),
        .roll_v_o         (roll_v_o),
        .clr_v_o          (clr_v_o),
        .inflight_o       (inflight_o),
        .busy_o           (busy_o),
        .roll_cnt_o       (roll_cnt_o),
        .clr_cnt_o        (clr_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive one cycle of inputs, check the combinational outputs mid-cycle, then clock.
    task automatic step(input string tag, input logic fv, dr, cm, fl, rd,
                        input logic ey, ed, er, ec);
        fe_queue_v_i     = fv;
        dispatch_ready_i = dr;
        commit_v_i       = cm;
        flush_v_i        = fl;
        redirect_v_i     = rd;
        #1;
        check({tag, ".yumi"}, fe_queue_yumi_o, ey);
        check({tag, ".deq"},  deq_v_o,         ed);
        check({tag, ".roll"}, roll_v_o,        er);
        check({tag, ".clr"},  clr_v_o,         ec);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_regs(input string tag, input int exp_inflight, input logic exp_busy);
        check({tag, ".inflight"}, inflight_o, exp_inflight);
        check({tag, ".busy"},     busy_o,     exp_busy);
    endtask

    // Hold reset with every input active; all command outputs must stay low.
    task automatic do_reset(input int cycles);
        reset_i = 1'b1;
        for (int i = 0; i < cycles; i++)
            step("rst", 1, 1, 1, 1, 1, 0, 0, 0, 0);
        reset_i          = 1'b0;
        fe_queue_v_i     = 1'b0;
        dispatch_ready_i = 1'b0;
        commit_v_i       = 1'b0;
        flush_v_i        = 1'b0;
        redirect_v_i     = 1'b0;
        #1;
        check_regs("post_rst", 0, 1'b0);
        check("post_rst.roll_cnt", roll_cnt_o, 0);
        check("post_rst.clr_cnt",  clr_cnt_o,  0);
    endtask

    initial begin
        reset_i = 1'b1;
        do_reset(2);

        // Three yumis then three commits.
        for (int i = 1; i <= 3; i++) begin
            step("t1_yumi", 1, 1, 0, 0, 0, 1, 0, 0, 0);
            check_regs("t1_yumi", i, 1'b0);
        end
        for (int i = 2; i >= 0; i--) begin
            step("t1_commit", 0, 0, 1, 0, 0, 0, 1, 0, 0);
            check_regs("t1_commit", i, 1'b0);
        end

        // Flush with commit at inflight 4: roll wins, count goes to 0, stay in e_run.
        for (int i = 0; i < 4; i++) step("t2_fill", 1, 1, 0, 0, 0, 1, 0, 0, 0);
        check_regs("t2_fill", 4, 1'b0);
        step("t2_flush_commit", 1, 1, 1, 1, 0, 0, 1, 1, 0);
        check_regs("t2_flush_commit", 0, 1'b0);

        // Redirect-only at t: clr at t, busy t+1..t+3, yumi at t+4.
        step("t3_redir", 1, 1, 0, 0, 1, 0, 0, 0, 1);
        check_regs("t3_redir", 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("t3_block", 1, 1, 0, 0, 0, 0, 0, 0, 0);
            check_regs("t3_block", 0, (k < 2));
        end
        step("t3_yumi", 1, 1, 0, 0, 0, 1, 0, 0, 0);
        check_regs("t3_yumi", 1, 1'b0);
        step("t3_commit", 0, 0, 1, 0, 0, 0, 1, 0, 0);

        // Flush+redirect at t: roll at t, clr at t+1, busy through t+4, yumi at t+5.
        step("t4_flush_redir", 1, 1, 0, 1, 1, 0, 0, 1, 0);
        check_regs("t4_flush_redir", 0, 1'b1);
        step("t4_clr", 1, 1, 0, 0, 0, 0, 0, 0, 1);
        check_regs("t4_clr", 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("t4_block", 1, 1, 0, 0, 0, 0, 0, 0, 0);
            check_regs("t4_block", 0, (k < 2));
        end
        step("t4_yumi", 1, 1, 0, 0, 0, 1, 0, 0, 0);
        check_regs("t4_yumi", 1, 1'b0);
        step("t4_commit", 0, 0, 1, 0, 0, 0, 1, 0, 0);

        // Redirect at t and t+2, flush at t+3 during resync: yumi first at t+6.
        step("t5_redir", 1, 1, 0, 0, 1, 0, 0, 0, 1);
        step("t5_idle", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("t5_redir2", 1, 1, 0, 0, 1, 0, 0, 0, 1);
        step("t5_flush", 1, 1, 0, 1, 0, 0, 0, 1, 0);
        check_regs("t5_flush", 0, 1'b1);
        step("t5_block", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("t5_block", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        check_regs("t5_block", 0, 1'b0);
        step("t5_yumi", 1, 1, 0, 0, 0, 1, 0, 0, 0);
        check_regs("t5_yumi", 1, 1'b0);

        // Reset in the middle of a resync window returns to e_run with inflight cleared.
        step("t6_yumi", 1, 1, 0, 0, 0, 1, 0, 0, 0);
        check_regs("t6_yumi", 2, 1'b0);
        step("t6_redir", 1, 1, 0, 0, 1, 0, 0, 0, 1);
        step("t6_idle", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("t6_redir2", 1, 1, 0, 0, 1, 0, 0, 0, 1);
        check_regs("t6_redir2", 2, 1'b1);
        do_reset(1);
        step("t6_yumi_after_rst", 1, 1, 0, 0, 0, 1, 0, 0, 0);
        check_regs("t6_yumi_after_rst", 1, 1'b0);

        // Event counters: two flushes and one redirect after a fresh reset.
        do_reset(1);
        step("t7_flush", 0, 0, 0, 1, 0, 0, 0, 1, 0);
        step("t7_flush", 0, 0, 0, 1, 0, 0, 0, 1, 0);
        step("t7_redir", 0, 0, 0, 0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step("t7_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_regs("t7_done", 0, 1'b0);
`ifdef BP_BE_ISSUE_CTRL_STATS_EN
        check("t7.roll_cnt", roll_cnt_o, 2);
        check("t7.clr_cnt",  clr_cnt_o,  1);
`else
        check("t7.roll_cnt", roll_cnt_o, 0);
        check("t7.clr_cnt",  clr_cnt_o,  0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
